// File: rtl/egress_serializer_if.sv
// Signal bundle between the router destination FIFO, the egress link and the serializer.
// The slave modport is the serializer side; the master modport is the FIFO/link side.
interface egress_serializer_if #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          cycle;
  logic [WIDTH-1:0]     data_in;
  logic                 empty;
  logic                 pop;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_first;
  logic                 out_last;
  logic [CNT_WIDTH-1:0] word_count;
  logic [31:0]          last_pop_cycle;

  modport slave (
    input  cycle, data_in, empty, out_ready,
    output pop, out_valid, out_data, out_first, out_last, word_count, last_pop_cycle
  );

  modport master (
    output cycle, data_in, empty, out_ready,
    input  pop, out_valid, out_data, out_first, out_last, word_count, last_pop_cycle
  );
endinterface

// File: rtl/egress_serializer.sv
// Pops 64-bit words from a fall-through FIFO and emits them LSB-beat-first on a
// valid/ready link, refilling on the last-beat handshake so words stream without bubbles.
module egress_serializer #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  egress_serializer_if.slave  io_bus
);
  localparam int RATIO = WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_shreg;
  logic [BW-1:0]        r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_word_count;
  logic [31:0]          r_last_pop_cycle;
  logic                 w_send;
  logic                 w_last_beat;
  logic                 w_hs;
  logic                 w_pop;

  assign w_send      = (r_state == S_SEND);
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_hs        = w_send & io_bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A refill is only allowed once the held word has no beats left after this cycle.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!io_bus.empty) begin
          w_pop        = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs && w_last_beat) begin
          if (!io_bus.empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (reset) begin
      w_pop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg          <= '0;
      r_beat_cnt       <= '0;
      r_word_count     <= '0;
      r_last_pop_cycle <= '0;
    end else begin
      if (w_pop) begin
        r_shreg          <= io_bus.data_in;
        r_beat_cnt       <= '0;
        r_last_pop_cycle <= io_bus.cycle;
      end else if (w_hs) begin
        r_shreg    <= r_shreg >> OUT_WIDTH;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_hs && w_last_beat) begin
        r_word_count <= r_word_count + 1'b1;
      end
    end
  end

  // Beat outputs depend on state only, so out_ready never reaches out_valid.
  always_comb begin
    io_bus.pop            = w_pop;
    io_bus.out_valid      = w_send;
    io_bus.out_data       = w_send ? r_shreg[OUT_WIDTH-1:0] : '0;
    io_bus.out_first      = w_send && (r_beat_cnt == '0);
    io_bus.out_last       = w_send && w_last_beat;
    io_bus.word_count     = r_word_count;
    io_bus.last_pop_cycle = r_last_pop_cycle;
  end
endmodule

// File: doc/egress_serializer.md
# egress_serializer

Drains the router's destination FIFO (8-entry, 64-bit) and serializes each 64-bit word onto a narrower valid/ready egress link, least-significant beat first. It is the stage directly downstream of the router's destination FIFO. It sustains one beat per cycle with no bubble between consecutive words. It also exposes a delivered-word counter and the cycle stamp of the most recent FIFO pop for debug.

## Interface
- WIDTH, 64, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, egress beat width; RATIO = WIDTH/OUT_WIDTH (default 4), RATIO >= 2.
- CNT_WIDTH, 16, width of word_count.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cycle  input  32  free-running system cycle count, shared with the rest of the router.
- data_in  input  WIDTH  FIFO head word; first-word fall-through, valid whenever empty=0.
- empty  input  1  FIFO empty flag.
- pop  output  1  consumes the FIFO head this cycle; combinational, only asserted when empty=0.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  OUT_WIDTH  beat payload.
- out_first  output  1  beat 0 of a word.
- out_last  output  1  beat RATIO-1 of a word.
- word_count  output  CNT_WIDTH  words fully delivered (last beat accepted); wraps modulo 2^CNT_WIDTH.
- last_pop_cycle  output  32  value of cycle sampled on the most recent pop.

## Operation
- State machine with two states:
  - IDLE: no word held.
  - SEND: word held in shift register shreg[WIDTH-1:0] with beat counter beat_cnt in 0..RATIO-1.
- IDLE with empty=0:
  - pop=1.
  - shreg <= data_in, beat_cnt <= 0, last_pop_cycle <= cycle.
  - Go to SEND.
- IDLE with empty=1: pop=0; stay in IDLE.
- SEND outputs:
  - out_valid=1, out_data=shreg[OUT_WIDTH-1:0].
  - out_first=(beat_cnt==0), out_last=(beat_cnt==RATIO-1).
- SEND with handshake (out_valid & out_ready) and beat_cnt<RATIO-1: shreg shifts right by OUT_WIDTH; beat_cnt++.
- SEND with handshake and beat_cnt==RATIO-1:
  - word_count++.
  - If empty=0: pop=1 in the same cycle, load data_in as above, stay in SEND (no bubble).
  - Else: go to IDLE.
- SEND without handshake: hold all state. out_data, out_first and out_last remain stable; pop=0.
- pop is never asserted while a held word still has beats outstanding. It is never asserted when empty=1.
- Reset values:
  - State IDLE, beat_cnt 0, shreg 0.
  - out_valid, out_first, out_last, out_data all 0.
  - word_count 0, last_pop_cycle 0, pop 0.
- Reset mid-word: the held word is discarded and not re-popped. word_count does not increment for it.
- out_valid, out_data, out_first, out_last, word_count and last_pop_cycle are registered or derived only from state. pop is the only output combinational on inputs (empty, out_ready).

## Timing
- Pop-to-first-beat latency: pop in cycle N gives out_valid=1 with beat 0 in cycle N+1.
- Sustained throughput with out_ready=1: one beat per cycle; one pop every RATIO cycles.
- out_valid never deasserts before its beat is accepted.
- word_count updates in the cycle after the last-beat handshake.
- last_pop_cycle updates in the cycle after the pop.
- No out_ready-to-out_valid combinational path.

## Test plan
- Single word: FIFO holds 0x0123456789ABCDEF, out_ready=1, pop in cycle N.
  - Beats 0xCDEF, 0x89AB, 0x4567, 0x0123 in cycles N+1..N+4.
  - out_first only with 0xCDEF; out_last only with 0x0123.
  - word_count=1 in N+5; FSM back in IDLE.
- Back-to-back: 3 words queued, out_ready=1.
  - 12 consecutive valid beats with no gap.
  - pop asserted in cycles N, N+4, N+8 only; word_count=3.
- Backpressure: out_ready=0 for 5 cycles during beat 2.
  - out_data, out_first and out_last are held stable; beat_cnt is held.
  - No pop during the stall.
  - The stream resumes at beat 2 with no loss or duplication.
- Empty FIFO: empty=1 for 20 cycles after reset.
  - pop=0 and out_valid=0 throughout.
  - word_count=0 and last_pop_cycle=0.
- Reset mid-word: assert reset after beat 1 is accepted.
  - The next cycle shows all outputs at reset values.
  - The next FIFO word is delivered from beat 0; word_count stays 0.
- Counter wrap and stamp: CNT_WIDTH=4, 17 words delivered.
  - word_count wraps to 1.
  - last_pop_cycle equals the cycle value sampled at the 17th pop.
